// File: rtl/vz_ram_injector_if.sv
// Loader / CPU-port / RAM-write signal bundle for vz_ram_injector.
// The checksum signal exists only when VZ_INJ_CHECKSUM_EN is defined.
interface vz_ram_injector_if;
    logic        ld_wr;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_busy;
    logic        cpu_mreq;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        cpu_wait;
    logic        overflow;
    logic        done;
`ifdef VZ_INJ_CHECKSUM_EN
    logic [7:0]  checksum;

    modport master (
        output ld_wr, ld_addr, ld_data, ld_busy, cpu_mreq,
        input  ram_addr, ram_din, ram_we, cpu_wait, overflow, done, checksum
    );
    modport slave (
        input  ld_wr, ld_addr, ld_data, ld_busy, cpu_mreq,
        output ram_addr, ram_din, ram_we, cpu_wait, overflow, done, checksum
    );
`else
    modport master (
        output ld_wr, ld_addr, ld_data, ld_busy, cpu_mreq,
        input  ram_addr, ram_din, ram_we, cpu_wait, overflow, done
    );
    modport slave (
        input  ld_wr, ld_addr, ld_data, ld_busy, cpu_mreq,
        output ram_addr, ram_din, ram_we, cpu_wait, overflow, done
    );
`endif
endinterface

// File: rtl/vz_ram_injector.sv
// Queues loader byte writes and injects them into RAM in cycles the CPU leaves free.
// Optional running byte checksum enabled by defining VZ_INJ_CHECKSUM_EN.
module vz_ram_injector #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    vz_ram_injector_if.slave     bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        WRITE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]   last_addr_q, last_addr_d;
    logic            ld_wr_q;
    logic            ld_busy_q;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_din_q, ram_din_d;
    logic            ram_we_q, ram_we_d;
    logic            cpu_wait_q, cpu_wait_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
`ifdef VZ_INJ_CHECKSUM_EN
    logic [DW-1:0]   checksum_q, checksum_d;
`endif

    logic   accept;
    logic   busy_rise;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    assign head = mem_q[rd_ptr_q];

    // Next-state, FIFO bookkeeping and registered-output values
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_addr_d = last_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        cpu_wait_d  = 1'b0;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
`ifdef VZ_INJ_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif

        // A held strobe only counts again once the address moves on
        accept    = bus.ld_wr && (!ld_wr_q || (bus.ld_addr != last_addr_q));
        busy_rise = bus.ld_busy && !ld_busy_q;
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        pop       = (state_q == WRITE);
        push      = accept && (!full || pop);

        if (accept) begin
            last_addr_d = bus.ld_addr;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!bus.cpu_mreq) begin
                    ram_addr_d = head.addr;
                    ram_din_d  = head.data;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if ((count_q > CNT_W'(1)) || push) begin
                    state_d = ARM;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!empty) begin
                    state_d = ARM;
                end else if (!bus.ld_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ram_we_d   = (state_d == WRITE);
        cpu_wait_d = bus.ld_busy || (count_d != '0) || (state_d != IDLE);

        // A drop in the same cycle as a new load start still reports
        if (busy_rise) begin
            overflow_d = 1'b0;
        end
        if (accept && full && !pop) begin
            overflow_d = 1'b1;
        end

`ifdef VZ_INJ_CHECKSUM_EN
        checksum_d = (busy_rise ? '0 : checksum_q) + (ram_we_q ? ram_din_q : '0);
`endif
    end

    // State and control registers
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_addr_q <= '0;
            ld_wr_q     <= 1'b0;
            ld_busy_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            cpu_wait_q  <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef VZ_INJ_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_addr_q <= last_addr_d;
            ld_wr_q     <= bus.ld_wr;
            ld_busy_q   <= bus.ld_busy;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            cpu_wait_q  <= cpu_wait_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
`ifdef VZ_INJ_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    // FIFO storage; stale contents are unreachable once the pointers reset
    always_ff @(posedge I_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: bus.ld_addr, data: bus.ld_data};
        end
    end

    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.cpu_wait = cpu_wait_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
`ifdef VZ_INJ_CHECKSUM_EN
    assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_vz_ram_injector.sv
// Self-checking bench for vz_ram_injector: directed scenarios plus randomized
// load rounds checked against a queue-level model of the accept/drop rules.
module tb_vz_ram_injector;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;

    logic [23:0] wr_log [$];
    int          wr_cyc [$];

    vz_ram_injector_if bus ();

    vz_ram_injector #(.DEPTH(DEPTH)) dut (
        .I_CLK (clk),
        .I_RST (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every RAM write and done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wr_log.push_back({bus.ram_addr, bus.ram_din});
            wr_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic wr, input logic [15:0] a, input logic [7:0] d);
        bus.ld_wr   = wr;
        bus.ld_addr = a;
        bus.ld_data = d;
    endtask

    task automatic test_reset();
        logic [27:0] obs;
        bus.ld_wr = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.ld_busy = 0; bus.cpu_mreq = 0;
        rst = 1'b1;
        repeat (3) tick();
        obs = {bus.ram_we, bus.cpu_wait, bus.done, bus.overflow, bus.ram_addr, bus.ram_din};
        checks++;
        if (obs !== 28'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 28'h0);
        end
`ifdef VZ_INJ_CHECKSUM_EN
        checks++;
        if (bus.checksum !== 8'h00) begin
            errors++; $display("FAIL reset_checksum: got %h expected 00", bus.checksum);
        end
`endif
        rst = 1'b0;
        repeat (3) tick();
        obs = {bus.ram_we, bus.cpu_wait, bus.done, bus.overflow, bus.ram_addr, bus.ram_din};
        checks++;
        if (obs !== 28'h0) begin
            errors++; $display("FAIL post_reset_idle: got %h expected %h", obs, 28'h0);
        end
    endtask

    task automatic test_dedupe();
        wr_log.delete();
        bus.ld_busy = 1;
        tick();
        drive(1, 16'h7AE9, 8'h11);
        repeat (3) tick();
        drive(0, 16'h7AE9, 8'h11);
        repeat (15) tick();
        checks++;
        if (wr_log.size() !== 1) begin
            errors++; $display("FAIL dedupe_count: got %0d expected 1", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== 24'h7AE911) begin
                errors++; $display("FAIL dedupe_entry: got %h expected 7ae911", wr_log[0]);
            end
        end
        bus.ld_busy = 0;
        repeat (5) tick();
    endtask

    task automatic test_burst();
        int acc;
        int t;
        int drop;
        logic [23:0] exp_e;
        wr_log.delete(); wr_cyc.delete(); done_cnt = 0;
        bus.ld_busy = 1;
        tick();
        acc = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h8000 + 16'(i), 8'(i + 1));
            tick();
        end
        drive(0, 16'h8003, 8'h04);
        t = 0;
        while (wr_log.size() < 4 && t < 40) begin tick(); t++; end
        checks++;
        if (wr_log.size() !== 4) begin
            errors++; $display("FAIL burst_count: got %0d expected 4", wr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_e = {16'h8000 + 16'(i), 8'(i + 1)};
                checks++;
                if (wr_log[i] !== exp_e) begin
                    errors++; $display("FAIL burst_entry%0d: got %h expected %h", i, wr_log[i], exp_e);
                end
            end
            checks++;
            if (wr_cyc[0] !== acc + 3) begin
                errors++; $display("FAIL burst_latency: got cycle %0d expected %0d", wr_cyc[0], acc + 3);
            end
        end
        repeat (2) tick();
        checks++;
        if (done_cnt !== 0) begin
            errors++; $display("FAIL done_while_busy: got %0d pulses expected 0", done_cnt);
        end
        drop = cyc;
        bus.ld_busy = 0;
        repeat (4) tick();
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (done_cyc !== drop + 1) begin
            errors++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, drop + 1);
        end
        checks++;
        if (bus.cpu_wait !== 1'b0) begin
            errors++; $display("FAIL wait_after_done: got %b expected 0", bus.cpu_wait);
        end
    endtask

    task automatic test_cpu_stall();
        int t;
        wr_log.delete();
        bus.ld_busy = 1; bus.cpu_mreq = 1;
        tick();
        drive(1, 16'h1234, 8'h5A);
        tick();
        drive(0, 16'h1234, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.ram_we !== 1'b0 || bus.cpu_wait !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: got we=%b wait=%b expected we=0 wait=1", i, bus.ram_we, bus.cpu_wait);
            end
        end
        bus.cpu_mreq = 0;
        t = 0;
        while (wr_log.size() < 1 && t < 20) begin tick(); t++; end
        repeat (5) tick();
        checks++;
        if (wr_log.size() !== 1) begin
            errors++; $display("FAIL stall_count: got %0d expected 1", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== 24'h12345A) begin
                errors++; $display("FAIL stall_entry: got %h expected 12345a", wr_log[0]);
            end
        end
        bus.ld_busy = 0;
        repeat (5) tick();
    endtask

    task automatic test_overflow();
        int t;
        logic [23:0] exp_e;
        wr_log.delete();
        bus.ld_busy = 1; bus.cpu_mreq = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                checks++;
                if (bus.overflow !== 1'b0) begin
                    errors++; $display("FAIL overflow_early: got %b expected 0", bus.overflow);
                end
            end
            drive(1, 16'h9000 + 16'(i), 8'hA0 + 8'(i));
            tick();
        end
        drive(0, 16'h9005, 8'hA5);
        repeat (2) tick();
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_set: got %b expected 1", bus.overflow);
        end
        checks++;
        if (wr_log.size() !== 0) begin
            errors++; $display("FAIL overflow_held_writes: got %0d expected 0", wr_log.size());
        end
        bus.cpu_mreq = 0;
        t = 0;
        while (wr_log.size() < 4 && t < 40) begin tick(); t++; end
        repeat (10) tick();
        checks++;
        if (wr_log.size() !== 4) begin
            errors++; $display("FAIL overflow_count: got %0d expected 4", wr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_e = {16'h9000 + 16'(i), 8'hA0 + 8'(i)};
                checks++;
                if (wr_log[i] !== exp_e) begin
                    errors++; $display("FAIL overflow_entry%0d: got %h expected %h", i, wr_log[i], exp_e);
                end
            end
        end
        bus.ld_busy = 0;
        repeat (3) tick();
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: got %b expected 1", bus.overflow);
        end
        bus.ld_busy = 1;
        repeat (2) tick();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++; $display("FAIL overflow_clear: got %b expected 0", bus.overflow);
        end
        bus.ld_busy = 0;
        repeat (5) tick();
    endtask

`ifdef VZ_INJ_CHECKSUM_EN
    task automatic test_checksum();
        int t;
        logic [7:0] bytes [3];
        bytes[0] = 8'hF0; bytes[1] = 8'h20; bytes[2] = 8'h05;
        wr_log.delete();
        bus.ld_busy = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'hA000 + 16'(i), bytes[i]);
            tick();
        end
        drive(0, 16'hA002, 8'h05);
        t = 0;
        while (wr_log.size() < 3 && t < 30) begin tick(); t++; end
        repeat (3) tick();
        checks++;
        if (bus.checksum !== 8'h15) begin
            errors++; $display("FAIL checksum_value: got %h expected 15", bus.checksum);
        end
        bus.ld_busy = 0;
        repeat (5) tick();
    endtask
`endif

    // Model: apply the accept rule per cycle; with the CPU holding the port from
    // an empty FIFO nothing drains, so the first DEPTH accepts are kept in order.
    task automatic test_random();
        logic [23:0] exp_q [$];
        logic [15:0] last_acc;
        logic        prev_wr;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  sum;
        int          nacc;
        int          ncyc;
        int          t;
        last_acc = 16'h0;
        for (int r = 0; r < 20; r++) begin
            exp_q.delete(); wr_log.delete();
            nacc = 0; prev_wr = 1'b0; sum = 8'h00;
            bus.ld_busy = 1; bus.cpu_mreq = 1;
            tick();
            ncyc = int'($urandom_range(2, 10));
            for (int c = 0; c < ncyc; c++) begin
                wr = ($urandom_range(0, 3) != 0);
                a  = 16'h4000 + 16'($urandom_range(0, 3));
                d  = 8'($urandom);
                drive(wr, a, d);
                if (wr && (!prev_wr || a != last_acc)) begin
                    nacc++;
                    last_acc = a;
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back({a, d});
                        sum = sum + d;
                    end
                end
                prev_wr = wr;
                tick();
            end
            drive(0, 16'h0, 8'h0);
            repeat (2) tick();
            checks++;
            if (bus.overflow !== (nacc > DEPTH)) begin
                errors++; $display("FAIL rand%0d_overflow: got %b expected %b (accepts %0d)", r, bus.overflow, nacc > DEPTH, nacc);
            end
            bus.cpu_mreq = 0;
            t = 0;
            while (wr_log.size() < exp_q.size() && t < 60) begin tick(); t++; end
            repeat (6) tick();
            checks++;
            if (wr_log.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d expected %0d", r, wr_log.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (wr_log[i] !== exp_q[i]) begin
                        errors++; $display("FAIL rand%0d_entry%0d: got %h expected %h", r, i, wr_log[i], exp_q[i]);
                    end
                end
            end
`ifdef VZ_INJ_CHECKSUM_EN
            checks++;
            if (bus.checksum !== sum) begin
                errors++; $display("FAIL rand%0d_checksum: got %h expected %h", r, bus.checksum, sum);
            end
`endif
            bus.ld_busy = 0;
            repeat (5) tick();
        end
    endtask

    task automatic test_reset_mid_write();
        int t;
        logic [27:0] obs;
        wr_log.delete();
        bus.ld_busy = 1; bus.cpu_mreq = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'hB000 + 16'(i), 8'hC0 + 8'(i));
            tick();
        end
        drive(0, 16'h0, 8'h0);
        tick();
        bus.cpu_mreq = 0;
        t = 0;
        while (bus.ram_we !== 1'b1 && t < 20) begin tick(); t++; end
        checks++;
        if (bus.ram_we !== 1'b1) begin
            errors++; $display("FAIL rstmid_write_seen: got %b expected 1", bus.ram_we);
        end
        rst = 1'b1; bus.ld_busy = 0;
        tick();
        obs = {bus.ram_we, bus.cpu_wait, bus.done, bus.overflow, bus.ram_addr, bus.ram_din};
        checks++;
        if (obs !== 28'h0) begin
            errors++; $display("FAIL rstmid_outputs: got %h expected %h", obs, 28'h0);
        end
`ifdef VZ_INJ_CHECKSUM_EN
        checks++;
        if (bus.checksum !== 8'h00) begin
            errors++; $display("FAIL rstmid_checksum: got %h expected 00", bus.checksum);
        end
`endif
        rst = 1'b0;
        repeat (20) tick();
        checks++;
        if (wr_log.size() !== 1) begin
            errors++; $display("FAIL rstmid_no_more_writes: got %0d expected 1", wr_log.size());
        end
        checks++;
        if (bus.cpu_wait !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got wait=%b done=%b expected 0 0", bus.cpu_wait, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_dedupe();
        test_burst();
        test_cpu_stall();
        test_overflow();
`ifdef VZ_INJ_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vz_ram_injector.md
VZ_RAM_INJECTOR -- requirements
Module: vz_ram_injector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-FIFO entries; power of two, 2..16.
REQ-002 SHALL have I_CLK  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have I_RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ld_wr  input  1  loader write strobe; may stay high for many cycles.
REQ-005 SHALL have ld_addr  input  16  loader target address.
REQ-006 SHALL have ld_data  input  8  loader data byte.
REQ-007 SHALL have ld_busy  input  1  download in progress.
REQ-008 SHALL have cpu_mreq  input  1  CPU owns the RAM port this cycle.
REQ-009 SHALL have ram_addr  output  16  RAM write address.
REQ-010 SHALL have ram_din  output  8  RAM write data.
REQ-011 SHALL have ram_we  output  1  RAM write enable, one-cycle pulse per byte.
REQ-012 SHALL have cpu_wait  output  1  stalls the CPU while an injection is pending.
REQ-013 SHALL have overflow  output  1  sticky; a write was lost because the FIFO was full.
REQ-014 SHALL have done  output  1  one-cycle pulse when a load completes and drains.
REQ-015 SHALL have checksum  output  8  running byte sum; present only with the REQ-032 macro.

Function
REQ-016 SHALL accept a write when ld_wr=1 and either ld_wr was 0 last cycle or ld_addr differs from the last accepted address.
REQ-017 SHALL ignore cycles with ld_wr=1 and ld_addr equal to the last accepted address; no new FIFO entry.
REQ-018 SHALL push each accepted {ld_addr, ld_data} into a DEPTH-entry FIFO with wrap-around pointers and a count of width clog2(DEPTH)+1.
REQ-019 SHALL, on an accept while the FIFO is full and no pop occurs that cycle, drop the entry and set overflow.
REQ-020 SHALL allow a simultaneous push and pop when full; count is unchanged and the entry is stored.
REQ-021 SHALL implement states IDLE, ARM, WRITE, DRAIN.
REQ-022 SHALL transition IDLE->ARM when the FIFO is non-empty.
REQ-023 SHALL, in ARM, wait until cpu_mreq=0, then load ram_addr/ram_din from the FIFO head and go to WRITE.
REQ-024 SHALL, in WRITE, assert ram_we for exactly one cycle and pop the head; go to ARM if entries remain, else DRAIN.
REQ-025 SHALL, in DRAIN, go to ARM if the FIFO becomes non-empty, otherwise pulse done and go to IDLE once ld_busy=0.
REQ-026 SHALL assert cpu_wait whenever ld_busy=1, the FIFO is non-empty, or the state is not IDLE.
REQ-027 SHALL meet latency: accept in cycle N -> ram_we in cycle N+3 at the earliest, with cpu_mreq=0 and the FIFO previously empty.
REQ-028 SHALL keep ram_addr/ram_din stable from ARM exit through the ram_we cycle.
REQ-029 SHALL clear overflow only on reset or on a rising edge of ld_busy (start of a new load).

Reset
REQ-030 SHALL, on I_RST=1, empty the FIFO, clear the last-address register and edge detector, set the state to IDLE, and drive ram_we=0, cpu_wait=0, done=0, overflow=0, ram_addr=0, ram_din=0, checksum=0.
REQ-031 SHALL, on reset mid-operation (including during WRITE), abandon pending entries with no further ram_we pulses.

Configuration
REQ-032 SHALL, with macro VZ_INJ_CHECKSUM_EN defined, add each byte written (ram_we=1) to checksum mod 256, clearing it on reset and on a rising edge of ld_busy; without the macro, the checksum port and its logic are absent.

Verification
REQ-033 SHALL test: ld_busy=1, ld_wr held high for 3 cycles with ld_addr 0x7AE9 constant, data 0x11 -> exactly one ram_we, address 0x7AE9, data 0x11.
REQ-034 SHALL test: bytes 0x01..0x04 to 0x8000..0x8003, one per cycle, cpu_mreq=0 -> four ram_we pulses in order; the first at accept+3; done pulses one cycle after drain once ld_busy=0.
REQ-035 SHALL test: cpu_mreq=1 held for 10 cycles with 1 entry queued -> no ram_we while cpu_mreq=1; write occurs after cpu_mreq falls; cpu_wait high throughout.
REQ-036 SHALL test: DEPTH=4, cpu_mreq=1, 6 distinct accepts -> 4 stored, overflow=1; after release exactly 4 writes; the next ld_busy rise clears overflow.
REQ-037 SHALL test: I_RST asserted during WRITE with 3 entries queued -> ram_we=0 from the next cycle; no later writes; all outputs at reset values.
REQ-038 SHALL test: with VZ_INJ_CHECKSUM_EN defined, bytes 0xF0, 0x20, 0x05 -> checksum=0x15.
